// File: rtl/seg_word_pkg.sv
// Shared constants for the seven-segment word readback path: segment bit order,
// decode patterns (bit6=g .. bit0=a, active-low), ASCII constants and the reader FSM states.
package seg_word_pkg;

  localparam int NUM_DIGITS = 5;
  localparam int SEG_W      = 7;
  localparam int WORD_W     = SEG_W * NUM_DIGITS;

  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_H     = 7'b0001001;
  localparam logic [SEG_W-1:0] SEG_L     = 7'b1000111;
  localparam logic [SEG_W-1:0] SEG_P     = 7'b0001100;
  localparam logic [SEG_W-1:0] SEG_U     = 7'b1000001;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [7:0] CH_QMARK = 8'h3F;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [WORD_W-1:0] WORD_BLANK = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } rd_state_e;

endpackage

// File: rtl/seg7_to_ascii.sv
// Combinational active-low seven-segment pattern to ASCII lookup.
// Unknown patterns return '?' with err set; 1000000 always decodes to '0'.
module seg7_to_ascii
  import seg_word_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [7:0]       ascii,
  output logic             err
);

  always_comb begin
    ascii = CH_QMARK;
    err   = 1'b0;
    case (seg)
      SEG_0:     ascii = 8'h30;
      SEG_1:     ascii = 8'h31;
      SEG_2:     ascii = 8'h32;
      SEG_3:     ascii = 8'h33;
      SEG_4:     ascii = 8'h34;
      SEG_5:     ascii = 8'h35;
      SEG_6:     ascii = 8'h36;
      SEG_7:     ascii = 8'h37;
      SEG_8:     ascii = 8'h38;
      SEG_9:     ascii = 8'h39;
      SEG_A:     ascii = 8'h41;
      SEG_B:     ascii = 8'h62;
      SEG_C:     ascii = 8'h43;
      SEG_D:     ascii = 8'h64;
      SEG_E:     ascii = 8'h45;
      SEG_F:     ascii = 8'h46;
      SEG_H:     ascii = 8'h48;
      SEG_L:     ascii = 8'h4C;
      SEG_P:     ascii = 8'h50;
      SEG_U:     ascii = 8'h55;
      SEG_DASH:  ascii = 8'h2D;
      SEG_BLANK: ascii = CH_SPACE;
      default: begin
        ascii = CH_QMARK;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_word_reader.sv
// Debounces the five display buses and replays a newly stable word as a
// left-to-right ASCII stream. Optional err_count port: define SEG_WORD_READER_ERRCNT_EN.
//
// state  | meaning
// S_IDLE | tracking stability, waiting for a stable word that differs from the last one sent
// S_EMIT | presenting snapshot digit[idx] on the valid/ready stream
module seg_word_reader
  import seg_word_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEG_W-1:0] seg_p,
  input  logic [SEG_W-1:0] seg_q,
  input  logic [SEG_W-1:0] seg_r,
  input  logic [SEG_W-1:0] seg_s,
  input  logic [SEG_W-1:0] seg_t,
  output logic [7:0]       char_data,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             char_last,
  output logic             char_err,
  output logic             busy
`ifdef SEG_WORD_READER_ERRCNT_EN
  , output logic [7:0]     err_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [WORD_W-1:0] seg_in, samp, snap, snap_nx, last_word, last_nx;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        idx, idx_nx;
  rd_state_e         state, state_nx;
  logic [SEG_W-1:0]  cur_seg;
  logic [7:0]        dec_ascii;
  logic              dec_err;
  logic              hs;

  assign seg_in = {seg_p, seg_q, seg_r, seg_s, seg_t};

  // Stability counter compares the live buses against last cycle's sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp <= WORD_BLANK;
      cnt  <= '0;
    end else begin
      samp <= seg_in;
      if (seg_in != samp)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      snap      <= WORD_BLANK;
      last_word <= WORD_BLANK;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      snap      <= snap_nx;
      last_word <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    snap_nx  = snap;
    last_nx  = last_word;
    case (state)
      S_IDLE: begin
        if (cnt == CNT_MAX && samp != last_word) begin
          state_nx = S_EMIT;
          idx_nx   = '0;
          snap_nx  = samp;
        end
      end
      S_EMIT: begin
        if (char_ready) begin
          if (idx == IDX_LAST) begin
            state_nx = S_IDLE;
            idx_nx   = '0;
            last_nx  = snap;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cur_seg = snap[SEG_W-1:0];
    case (idx)
      3'd0:    cur_seg = snap[5*SEG_W-1:4*SEG_W];
      3'd1:    cur_seg = snap[4*SEG_W-1:3*SEG_W];
      3'd2:    cur_seg = snap[3*SEG_W-1:2*SEG_W];
      3'd3:    cur_seg = snap[2*SEG_W-1:SEG_W];
      default: cur_seg = snap[SEG_W-1:0];
    endcase
  end

  seg7_to_ascii u_dec (
    .seg   (cur_seg),
    .ascii (dec_ascii),
    .err   (dec_err)
  );

  // Outputs are qualified by EMIT so everything reads zero while idle or in reset.
  assign char_valid = (state == S_EMIT);
  assign busy       = char_valid;
  assign char_data  = char_valid ? dec_ascii : 8'h00;
  assign char_err   = char_valid & dec_err;
  assign char_last  = char_valid & (idx == IDX_LAST);
  assign hs         = char_valid & char_ready;

`ifdef SEG_WORD_READER_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= 8'd0;
    else if (hs && char_err && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_seg_word_reader.sv
// Directed bench for seg_word_reader: table of words with hand-decoded text,
// plus stall, debounce, reset-abort and (with SEG_WORD_READER_ERRCNT_EN) error-count sequences.
module tb_seg_word_reader;

  localparam logic [6:0] P_0 = 7'b1000000, P_1 = 7'b1111001, P_2 = 7'b0100100;
  localparam logic [6:0] P_3 = 7'b0110000, P_4 = 7'b0011001, P_5 = 7'b0010010;
  localparam logic [6:0] P_6 = 7'b0000010, P_7 = 7'b1111000, P_8 = 7'b0000000;
  localparam logic [6:0] P_9 = 7'b0010000, P_A = 7'b0001000, P_B = 7'b0000011;
  localparam logic [6:0] P_C = 7'b1000110, P_D = 7'b0100001, P_E = 7'b0000110;
  localparam logic [6:0] P_F = 7'b0001110, P_H = 7'b0001001, P_L = 7'b1000111;
  localparam logic [6:0] P_P = 7'b0001100, P_U = 7'b1000001, P_DASH = 7'b0111111;
  localparam logic [6:0] P_BL = 7'b1111111, P_BAD = 7'b0101010, P_BAD2 = 7'b0101011;
  localparam int LAT = 18;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] seg_p, seg_q, seg_r, seg_s, seg_t;
  logic [7:0] char_data;
  logic char_valid, char_ready, char_last, char_err, busy;
`ifdef SEG_WORD_READER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  seg_word_reader #(.STABLE_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_p      (seg_p),
    .seg_q      (seg_q),
    .seg_r      (seg_r),
    .seg_s      (seg_s),
    .seg_t      (seg_t),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_last  (char_last),
    .char_err   (char_err),
    .busy       (busy)
`ifdef SEG_WORD_READER_ERRCNT_EN
    , .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [34:0] segs;
    logic [39:0] chars;
    logic [4:0]  errs;
  } vec_t;

  vec_t tbl[8];
  int total = 0;
  int bad = 0;
  int hs_cnt = 0;

  always @(posedge clk) if (char_valid && char_ready) hs_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [34:0] w);
    {seg_p, seg_q, seg_r, seg_s, seg_t} = w;
  endtask

  task automatic latency(input string nm);
    int n = 0;
    do begin
      step();
      n++;
    end while (!char_valid && n < 200);
    chk({nm, " latency"}, n, LAT);
  endtask

  // Pulls one full word; with stall set, each character is held one cycle with ready low.
  task automatic collect(input logic [39:0] ch, input logic [4:0] er, input bit stall, input string nm);
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      logic [7:0] want;
      want = ch[39-8*k -: 8];
      while (!char_valid && n < 200) begin
        step();
        n++;
      end
      if (!char_valid) begin
        chk({nm, " timeout"}, 32'(char_valid), 1);
        return;
      end
      if (k > 0 && !stall) chk({nm, " gap"}, n, 0);
      chk({nm, " data"}, char_data, want);
      chk({nm, " err"}, char_err, er[k]);
      chk({nm, " last"}, char_last, (k == 4) ? 1 : 0);
      chk({nm, " busy"}, busy, 1);
      if (stall) begin
        char_ready = 1'b0;
        step();
        chk({nm, " held valid"}, char_valid, 1);
        chk({nm, " held data"}, char_data, want);
      end
      char_ready = 1'b1;
      step();
    end
    chk({nm, " idle after"}, char_valid, 0);
  endtask

  initial begin
    int vcnt;
    int hs0;
    tbl[0] = '{{P_H, P_E, P_L, P_L, P_0},          "HELL0", 5'b00000};
    tbl[1] = '{{P_DASH, P_DASH, P_DASH, P_DASH, P_DASH}, "-----", 5'b00000};
    tbl[2] = '{{P_H, P_E, P_BAD, P_L, P_0},        "HE?L0", 5'b00100};
    tbl[3] = '{{P_1, P_2, P_3, P_4, P_5},          "12345", 5'b00000};
    tbl[4] = '{{P_6, P_7, P_8, P_9, P_A},          "6789A", 5'b00000};
    tbl[5] = '{{P_B, P_C, P_D, P_E, P_F},          "bCdEF", 5'b00000};
    tbl[6] = '{{P_H, P_L, P_P, P_U, P_BL},         "HLPU ", 5'b00000};
    tbl[7] = '{{P_BL, P_BL, P_BL, P_BL, P_BL},     "     ", 5'b00000};

    rst_n = 1'b0;
    char_ready = 1'b1;
    apply({5{P_BL}});
    step();
    step();
    chk("reset valid", char_valid, 0);
    chk("reset data", char_data, 0);
    chk("reset last", char_last, 0);
    chk("reset err", char_err, 0);
    chk("reset busy", busy, 0);
`ifdef SEG_WORD_READER_ERRCNT_EN
    chk("reset errcnt", err_count, 0);
`endif
    rst_n = 1'b1;

    vcnt = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (char_valid) vcnt++;
    end
    chk("blank after reset not sent", vcnt, 0);

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].segs);
      latency($sformatf("vec%0d", i));
      collect(tbl[i].chars, tbl[i].errs, 1'b0, $sformatf("vec%0d", i));
`ifdef SEG_WORD_READER_ERRCNT_EN
      if (i == 2) chk("errcnt one", err_count, 1);
`endif
      if (i == 1) begin
        vcnt = 0;
        for (int c = 0; c < 100; c++) begin
          step();
          if (char_valid) vcnt++;
        end
        chk("no resend", vcnt, 0);
      end
    end

    // Ready toggling: every character must hold across its stall cycle.
    apply({P_0, P_1, P_2, P_3, P_4});
    hs0 = hs_cnt;
    collect("01234", 5'b00000, 1'b1, "stall");
    chk("stall handshakes", hs_cnt - hs0, 5);

    // seg_q flips every 10 cycles, never long enough to count as stable.
    apply({5{P_3}});
    vcnt = 0;
    for (int t = 0; t < 10; t++) begin
      for (int c = 0; c < 10; c++) begin
        step();
        if (char_valid) vcnt++;
      end
      seg_q = (seg_q == P_3) ? P_7 : P_3;
    end
    chk("toggle no valid", vcnt, 0);
    hs0 = hs_cnt;
    collect("33333", 5'b00000, 1'b0, "toggle stop");
    vcnt = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (char_valid) vcnt++;
    end
    chk("toggle once", vcnt, 0);
    chk("toggle handshakes", hs_cnt - hs0, 5);

    // Reset after the second handshake abandons the word; same word replays afterwards.
    apply({P_H, P_E, P_L, P_L, P_0});
    latency("rst word");
    step();
    step();
    chk("pre-reset data", char_data, 8'h4C);
    rst_n = 1'b0;
    #1;
    chk("abort valid", char_valid, 0);
    chk("abort data", char_data, 0);
    chk("abort last", char_last, 0);
    chk("abort busy", busy, 0);
    step();
    step();
    rst_n = 1'b1;
    latency("re-emit");
    collect("HELL0", 5'b00000, 1'b0, "re-emit");

`ifdef SEG_WORD_READER_ERRCNT_EN
    chk("errcnt after reset", err_count, 0);
    for (int w = 0; w < 300; w++) begin
      int n = 0;
      apply((w % 2 == 0) ? {P_H, P_E, P_BAD, P_L, P_0} : {P_H, P_E, P_BAD2, P_L, P_0});
      while (!busy && n < 100) begin
        step();
        n++;
      end
      n = 0;
      while (busy && n < 100) begin
        step();
        n++;
      end
    end
    chk("errcnt saturate", err_count, 255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_word_reader.md
Name: seg_word_reader

Overview:
- Reads the five active-low seven-segment buses driven by the word display and decodes them back into an ASCII character stream.
- Waits for a stable display pattern, then emits the five characters left to right (digit p first, digit t last) over a valid/ready stream.
- Used as a loopback checker and as the readback path for the display subsystem.

Parameters:
- STABLE_CYCLES, 16, consecutive cycles all five buses must hold unchanged before a word is accepted (minimum 1).
- CNT_W, $clog2(STABLE_CYCLES+1), width of the stability counter (derived; not overridden).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- seg_p, seg_q, seg_r, seg_s, seg_t  in  7 each  active-low segments; bit0=a … bit6=g, 0 = lit
- char_data  out  8  ASCII code of the current character
- char_valid  out  1  char_data valid
- char_ready  in  1  sink accepts when char_valid && char_ready
- char_last  out  1  high with the 5th character (digit t)
- char_err  out  1  high with any character whose pattern is not in the decode table
- busy  out  1  high while a word is being emitted

Behaviour:
- Reset (async assert, sync-deassert domain assumed upstream):
  - All outputs go to 0. char_data = 8'h00.
  - The sample register, last-word register and debounce count are set to all-ones/blank (35'h7FFFFFFFF, count 0).
  - FSM enters IDLE.
- Sampling:
  - The concatenation {p,q,r,s,t} is registered every cycle.
  - If the registered value differs from the previous sample, the count clears to 0.
  - Otherwise the count increments, saturating at STABLE_CYCLES.
- FSM states:
  - IDLE: when count == STABLE_CYCLES and the sample != last-word, capture the sample into the snapshot and go to EMIT with index 0. If the sample == last-word, stay in IDLE, so an unchanged word is never re-sent.
  - EMIT: char_valid = 1. char_data, char_err and char_last are decoded from snapshot digit[index] and must hold stable while valid && !ready. On the handshake, index increments. On the handshake at index 4, copy the snapshot to last-word and go to IDLE. busy = 1 throughout EMIT.
- Input changes during EMIT do not affect the snapshot. Debounce tracking keeps running, so a new stable word may start emitting the cycle after returning to IDLE.
- First character latency: char_valid rises 1 cycle after count reaches STABLE_CYCLES, i.e. STABLE_CYCLES+2 cycles after the inputs settle.
- Decode table (pattern in g..a order → ASCII):
  - 1000000→'0', 1111001→'1', 0100100→'2', 0110000→'3', 0011001→'4'
  - 0010010→'5', 0000010→'6', 1111000→'7', 0000000→'8', 0010000→'9'
  - 0001000→'A', 0000011→'b', 1000110→'C', 0100001→'d', 0000110→'E'
  - 0001110→'F', 0001001→'H', 1000111→'L', 0001100→'P', 1000001→'U'
  - 0111111→'-', 1111111→' '
  - Any other pattern → '?' with char_err = 1.
  - 1000000 decodes as '0', never 'O'.
- Reset asserted mid-word: the word is abandoned with no char_last, and after release the same word is re-emitted once stable.

Optional Feature:
- Macro SEG_WORD_READER_ERRCNT_EN.
- Defined: adds output err_count [7:0]. It increments on each accepted handshake with char_err = 1, saturates at 255, and resets to 0.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Package seg_word_pkg holds:
  - the segment bit-order constants;
  - the SEG_* pattern localparams ('H', 'E', 'L', '0', '-', blank, …);
  - the ASCII constants CH_QMARK and CH_SPACE;
  - a digit-count constant NUM_DIGITS = 5.
- Sub-module seg7_to_ascii: pure combinational 7-bit pattern → {err, ascii[7:0]} lookup, reusable by other readers.

Test Plan:
- Drive p..t = H,E,L,L,0 patterns (0001001, 0000110, 1000111, 1000111, 1000000) with ready = 1 → 'H','E','L','L','0' on 5 consecutive cycles starting at STABLE_CYCLES+2; char_last only on '0'; char_err = 0.
- Drive all five buses = 0111111 after the word above → five '-' characters; then hold for 100 cycles → no further valid.
- Toggle seg_q every 10 cycles with STABLE_CYCLES = 16 → char_valid never asserts; stop toggling → word emitted once.
- During EMIT, toggle ready 1-0-1-0 → each char_data value is held across stalls; exactly 5 handshakes occur.
- Drive seg_r = 0101010 → third character '?' with char_err = 1. With SEG_WORD_READER_ERRCNT_EN, err_count = 1; with 300 such words, err_count = 255.
- Assert rst_n low after the 2nd handshake → outputs go to 0 immediately. After release with an unchanged input, the full word re-emits starting from 'H'.
